// File: rtl/strobe_divider_if.sv
// Strobe output bundle for strobe_divider.
// The divider drives it through the master modport, and the consumer reads it through the slave modport.
interface strobe_divider_if;
    logic strobe;

    modport master (output strobe);
    modport slave  (input  strobe);
endinterface

// File: rtl/strobe_divider.sv
// Free-running clock-enable generator: one-cycle strobe every DIV clocks, phase restarted by reset.
// Optional embedded formal properties are compiled in when STROBE_DIV_FORMAL_EN is defined.
module strobe_divider #(
    parameter int DIV = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    strobe_divider_if.master  bus
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("strobe_divider: DIV must be >= 1");
        end
    endgenerate

    // Power-up value 0 so the phase is defined even before the first reset.
    logic [CW-1:0] cnt = '0;

    always_ff @(posedge i_clk) begin
        if (i_reset || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Gated by reset so the strobe drops in the same cycle reset is raised.
    assign bus.strobe = !i_reset && (cnt == LAST);

`ifdef STROBE_DIV_FORMAL_EN
    logic        f_past_valid = 1'b0;
    logic        f_armed = 1'b0;
    logic [31:0] f_gap = '0;

    always_ff @(posedge i_clk) begin
        f_past_valid <= 1'b1;
        if (i_reset) begin
            f_armed <= 1'b0;
            f_gap   <= '0;
        end else if (bus.strobe) begin
            f_armed <= 1'b1;
            f_gap   <= 32'd1;
        end else begin
            f_gap   <= f_gap + 32'd1;
        end
    end

    a_cnt_range: assert property (@(posedge i_clk) cnt <= LAST);
    a_no_strobe_in_reset: assert property (@(posedge i_clk) bus.strobe |-> !i_reset);
    a_single_cycle: assert property (@(posedge i_clk) disable iff (!f_past_valid)
        (DIV > 1 && !i_reset && bus.strobe) |=> !bus.strobe);
    a_period: assert property (@(posedge i_clk)
        (f_armed && !i_reset && bus.strobe) |-> f_gap == 32'(DIV));
    a_reset_clears: assert property (@(posedge i_clk)
        (f_past_valid && $past(i_reset)) |-> cnt == '0);
    c_two_strobes: cover property (@(posedge i_clk) f_armed && !i_reset && bus.strobe);
`endif

endmodule

// File: tb/tb_strobe_divider.sv
// Self-checking bench: four dividers (DIV 3, 1, 10, 5) exercised one at a time with a strobe scoreboard.
module tb_strobe_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [4];
    strobe_divider_if if3 ();
    strobe_divider_if if1 ();
    strobe_divider_if if10 ();
    strobe_divider_if if5 ();

    strobe_divider #(.DIV(3))  u_div3  (.i_clk(clk), .i_reset(rst[0]), .bus(if3.master));
    strobe_divider #(.DIV(1))  u_div1  (.i_clk(clk), .i_reset(rst[1]), .bus(if1.master));
    strobe_divider #(.DIV(10)) u_div10 (.i_clk(clk), .i_reset(rst[2]), .bus(if10.master));
    strobe_divider #(.DIV(5))  u_div5  (.i_clk(clk), .i_reset(rst[3]), .bus(if5.master));

    int div_of [4] = '{3, 1, 10, 5};
    int since_rel [4];
    bit sb [$];
    int compared = 0;
    int mismatched = 0;
    int strobes10 = 0;

    function automatic logic strobe_of(input int u);
        case (u)
            0: return if3.strobe;
            1: return if1.strobe;
            2: return if10.strobe;
            default: return if5.strobe;
        endcase
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // One clock cycle of unit u with reset value r; expectation is pushed, then popped at sampling.
    task automatic step(input int u, input bit r, input string tag);
        logic obs;
        bit   exp;
        @(negedge clk);
        rst[u] = r;
        if (r) since_rel[u] = 0;
        else   since_rel[u]++;
        sb.push_back(!r && (since_rel[u] % div_of[u] == 0));
        #1;
        obs = strobe_of(u);
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            exp = sb.pop_front();
            if (u == 2 && obs === 1'b1) strobes10++;
            check_bit(tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1;
            since_rel[i] = 0;
        end

        // Reset state of every instance.
        for (int u = 0; u < 4; u++) begin
            step(u, 1'b1, "reset_state");
        end

        // DIV=3: 2 reset cycles then 12 free-running cycles, strobes at 3, 6, 9, 12.
        step(0, 1'b1, "d3_reset");
        step(0, 1'b1, "d3_reset");
        for (int i = 0; i < 12; i++) step(0, 1'b0, "d3_run");

        // DIV=3: reassert reset in post-release cycle 2, then strobe on the 3rd deasserted cycle.
        step(0, 1'b1, "d3_midrst_hold");
        step(0, 1'b0, "d3_midrst_c1");
        step(0, 1'b1, "d3_midrst_rst");
        for (int i = 0; i < 4; i++) step(0, 1'b0, "d3_midrst_run");

        // DIV=3: reset lands exactly on the cnt==2 cycle.
        step(0, 1'b1, "d3_edge_hold");
        step(0, 1'b0, "d3_edge_c1");
        step(0, 1'b0, "d3_edge_c2");
        step(0, 1'b1, "d3_edge_rst_on_last");
        step(0, 1'b0, "d3_edge_after");
        check_bit("d3_edge_cnt_zero", (u_div3.cnt == 2'd0), 1'b1);
        step(0, 1'b1, "d3_park");

        // DIV=1: high every non-reset cycle, low immediately when reset rises.
        step(1, 1'b1, "d1_hold");
        for (int i = 0; i < 5; i++) step(1, 1'b0, "d1_run");
        step(1, 1'b1, "d1_rst_same_cycle");

        // DIV=10: 100 free-running cycles yield exactly 10 single-cycle strobes.
        step(2, 1'b1, "d10_hold");
        for (int i = 0; i < 100; i++) step(2, 1'b0, "d10_run");
        compared++;
        assert (strobes10 === 10) else begin
            mismatched++;
            $error("FAIL d10_count observed=%0d expected=10", strobes10);
        end
        step(2, 1'b1, "d10_park");

        // DIV=5: held in reset for 20 cycles, strobe and cnt stay 0.
        for (int i = 0; i < 20; i++) begin
            step(3, 1'b1, "d5_hold");
            check_bit("d5_hold_cnt", (u_div5.cnt == 3'd0), 1'b1);
        end

        compared++;
        assert (sb.size() == 0) else begin
            mismatched++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
